eclair_exec_unit: RTL and testbench
===================================

// Module: eclair_exec_unit
// PURPOSE
//  ECLair execution-support block: 16-bit 74181-style ALU (x,y -> z), a WIDTH-bit loadable
//  up-counter (program counter) and a 3-to-8 register-load decoder. ALU and decoder are
//  combinational; the counter is the only state. Sits between control-store word and registers.
// PARAMETERS
//  CNT_WIDTH  16  width of counter, preset and count output
// PORTS
//  clk          in   1          single system clock; all state updates on rising edge
//  reset        in   1          synchronous, active-high reset
//  cnt_en       in   1          counter increment enable
//  cnt_load     in   1          counter parallel-load request
//  cnt_preset   in   CNT_WIDTH  value loaded when cnt_load=1
//  cnt_out      out  CNT_WIDTH  counter value (registered)
//  alu_mode     in   1          0=arithmetic, 1=logic
//  alu_op       in   4          ALU function select S3..S0
//  alu_c_in     in   1          carry in, active-high (adds +1 in arithmetic mode)
//  alu_x        in   16         operand A
//  alu_y        in   16         operand B
//  alu_z        out  16         result (combinational)
//  dmx_sel      in   3          decoder select
//  dmx_out      out  8          one-hot decoder output, active-high
// BEHAVIOUR
//  Counter: priority reset > load > increment. reset=1 -> cnt_out=0. cnt_load=1 -> cnt_preset
//   next edge (ignores cnt_en). cnt_en=1 -> +1 mod 2^CNT_WIDTH (all-ones wraps to 0). Else hold.
//   Latency 1 clk; reset mid-count clears on that edge regardless of load/en.
//  Decoder: dmx_out = 1 << dmx_sel, exactly one bit set, purely combinational, unaffected by
//   reset. Code 0 (bit 0) is the idle/no-load code by convention.
//  ALU logic mode (alu_c_in ignored), op 0..F: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B,
//   ~A|B, ~(A^B), B, A&B, 16'hFFFF, A|~B, A|B, A.
//  ALU arithmetic mode, result = f + alu_c_in, mod 2^16, op 0..F: A, A|B, A|~B, -1,
//   A+(A&~B), (A|B)+(A&~B), A-B-1, (A&~B)-1, A+(A&B), A+B, (A|~B)+(A&B), (A&B)-1, A+A,
//   (A|B)+A, (A|~B)+A, A-1. "-1" terms are +16'hFFFF. Hence op 6 with c_in=1 = A-B.
//  ALU fully combinational, no reset dependence; X-free for all defined inputs.
// CONFIGURATION
//  ECLAIR_ALU_FLAGS_EN defined: extra outputs alu_c_out (carry out of bit 15, arithmetic mode;
//   0 in logic mode), alu_zero (alu_z==0), alu_eq (alu_x==alu_y), all combinational.
//  Undefined: these ports and their logic are absent; all other behaviour identical.
// STRUCTURE
//  Package eclair_exec_pkg: ALU mode constants (ALU_ARITH=0, ALU_LOGIC=1), localparams naming
//   the 16 op codes (e.g. OP_A_PLUS_B=4'h9, OP_A_MINUS_B_M1=4'h6, OP_XOR=4'h6), decoder width.
//  One sub-module: eclair_alu4_slice (4-bit 181 slice: mode, op, c_in, a, b -> f, c_out),
//   instantiated 4x with ripple carry to form the 16-bit ALU. Counter and decoder inline.
// TESTING
//  reset=1 one edge with cnt_load=1,cnt_en=1 -> cnt_out=0; then cnt_en=1 x3 -> 1,2,3.
//  cnt_load=1,cnt_preset=16'hFFFE,cnt_en=1 -> FFFE; then cnt_en x2 -> FFFF, 0000 (wrap).
//  dmx_sel 0..7 sweep -> dmx_out 8'h01,02,04,...,80; exactly one bit high each.
//  mode=0,op=9,x=1234,y=1111,c_in=0 -> z=2345; op=6,c_in=1,x=0005,y=0007 -> z=FFFE.
//  mode=1,x=F0F0,y=FF00: op=6 -> 0FF0; op=B -> F000; op=E -> FFF0; op=0 -> 0F0F; op=3 -> 0000.
//  With ECLAIR_ALU_FLAGS_EN: mode=0,op=9,x=FFFF,y=0001 -> z=0000,c_out=1,zero=1,eq=0.

Source files
------------

// File: rtl/eclair_exec_pkg.sv
// Shared constants for the ECLair execution-support block: ALU modes, op codes, decoder sizing.
// No logic; imported by the interface, the ALU slice and the top.
package eclair_exec_pkg;

  localparam logic ALU_ARITH = 1'b0;
  localparam logic ALU_LOGIC = 1'b1;

  // Logic-mode op codes (alu_mode = ALU_LOGIC)
  localparam logic [3:0] OP_NOT_A     = 4'h0;
  localparam logic [3:0] OP_NOR       = 4'h1;
  localparam logic [3:0] OP_NA_AND_B  = 4'h2;
  localparam logic [3:0] OP_ZERO      = 4'h3;
  localparam logic [3:0] OP_NAND      = 4'h4;
  localparam logic [3:0] OP_NOT_B     = 4'h5;
  localparam logic [3:0] OP_XOR       = 4'h6;
  localparam logic [3:0] OP_A_AND_NB  = 4'h7;
  localparam logic [3:0] OP_NA_OR_B   = 4'h8;
  localparam logic [3:0] OP_XNOR      = 4'h9;
  localparam logic [3:0] OP_PASS_B    = 4'hA;
  localparam logic [3:0] OP_AND       = 4'hB;
  localparam logic [3:0] OP_ONES      = 4'hC;
  localparam logic [3:0] OP_A_OR_NB   = 4'hD;
  localparam logic [3:0] OP_OR        = 4'hE;
  localparam logic [3:0] OP_PASS_A    = 4'hF;

  // Arithmetic-mode op codes (alu_mode = ALU_ARITH); result also adds alu_c_in
  localparam logic [3:0] OP_A_PLUS_C     = 4'h0;
  localparam logic [3:0] OP_MINUS_ONE    = 4'h3;
  localparam logic [3:0] OP_A_MINUS_B_M1 = 4'h6;
  localparam logic [3:0] OP_A_PLUS_B     = 4'h9;
  localparam logic [3:0] OP_A_PLUS_A     = 4'hC;
  localparam logic [3:0] OP_A_M1         = 4'hF;

  localparam int ALU_WIDTH  = 16;
  localparam int DMX_SEL_W  = 3;
  localparam int DMX_WIDTH  = 1 << DMX_SEL_W;

endpackage

// File: rtl/eclair_exec_unit_if.sv
// Bus bundle between the control store and the execution-support block.
// Flag outputs exist only when ECLAIR_ALU_FLAGS_EN is defined.
interface eclair_exec_unit_if #(parameter int CNT_WIDTH = 16);
  import eclair_exec_pkg::*;

  logic                 cnt_en;
  logic                 cnt_load;
  logic [CNT_WIDTH-1:0] cnt_preset;
  logic [CNT_WIDTH-1:0] cnt_out;
  logic                 alu_mode;
  logic [3:0]           alu_op;
  logic                 alu_c_in;
  logic [ALU_WIDTH-1:0] alu_x;
  logic [ALU_WIDTH-1:0] alu_y;
  logic [ALU_WIDTH-1:0] alu_z;
  logic [DMX_SEL_W-1:0] dmx_sel;
  logic [DMX_WIDTH-1:0] dmx_out;
`ifdef ECLAIR_ALU_FLAGS_EN
  logic                 alu_c_out;
  logic                 alu_zero;
  logic                 alu_eq;

  modport master (
    output cnt_en, cnt_load, cnt_preset, alu_mode, alu_op, alu_c_in, alu_x, alu_y, dmx_sel,
    input  cnt_out, alu_z, dmx_out, alu_c_out, alu_zero, alu_eq
  );
  modport slave (
    input  cnt_en, cnt_load, cnt_preset, alu_mode, alu_op, alu_c_in, alu_x, alu_y, dmx_sel,
    output cnt_out, alu_z, dmx_out, alu_c_out, alu_zero, alu_eq
  );
`else
  modport master (
    output cnt_en, cnt_load, cnt_preset, alu_mode, alu_op, alu_c_in, alu_x, alu_y, dmx_sel,
    input  cnt_out, alu_z, dmx_out
  );
  modport slave (
    input  cnt_en, cnt_load, cnt_preset, alu_mode, alu_op, alu_c_in, alu_x, alu_y, dmx_sel,
    output cnt_out, alu_z, dmx_out
  );
`endif

endinterface

// File: rtl/eclair_alu4_slice.sv
// 4-bit 74181-style ALU slice; combinational, no state.
// Arithmetic result is t1 + t2 + c_in, where "-1" terms appear as t2 = 4'hF per slice.
module eclair_alu4_slice
  import eclair_exec_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] op,
  input  logic       c_in,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] f,
  output logic       c_out
);

  logic [3:0] t1;
  logic [3:0] t2;
  logic [4:0] sum;

  always_comb begin
    t1    = a;
    t2    = 4'h0;
    sum   = 5'h00;
    f     = 4'h0;
    c_out = 1'b0;
    if (mode == ALU_LOGIC) begin
      case (op)
        OP_NOT_A:    f = ~a;
        OP_NOR:      f = ~(a | b);
        OP_NA_AND_B: f = ~a & b;
        OP_ZERO:     f = 4'h0;
        OP_NAND:     f = ~(a & b);
        OP_NOT_B:    f = ~b;
        OP_XOR:      f = a ^ b;
        OP_A_AND_NB: f = a & ~b;
        OP_NA_OR_B:  f = ~a | b;
        OP_XNOR:     f = ~(a ^ b);
        OP_PASS_B:   f = b;
        OP_AND:      f = a & b;
        OP_ONES:     f = 4'hF;
        OP_A_OR_NB:  f = a | ~b;
        OP_OR:       f = a | b;
        default:     f = a;
      endcase
    end else begin
      // An all-ones addend in every slice, rippled, is exactly +16'hFFFF.
      case (op)
        4'h0: begin t1 = a;          t2 = 4'h0;    end
        4'h1: begin t1 = a | b;      t2 = 4'h0;    end
        4'h2: begin t1 = a | ~b;     t2 = 4'h0;    end
        4'h3: begin t1 = 4'h0;       t2 = 4'hF;    end
        4'h4: begin t1 = a;          t2 = a & ~b;  end
        4'h5: begin t1 = a | b;      t2 = a & ~b;  end
        4'h6: begin t1 = a;          t2 = ~b;      end
        4'h7: begin t1 = a & ~b;     t2 = 4'hF;    end
        4'h8: begin t1 = a;          t2 = a & b;   end
        4'h9: begin t1 = a;          t2 = b;       end
        4'hA: begin t1 = a | ~b;     t2 = a & b;   end
        4'hB: begin t1 = a & b;      t2 = 4'hF;    end
        4'hC: begin t1 = a;          t2 = a;       end
        4'hD: begin t1 = a | b;      t2 = a;       end
        4'hE: begin t1 = a | ~b;     t2 = a;       end
        default: begin t1 = a;       t2 = 4'hF;    end
      endcase
      sum   = {1'b0, t1} + {1'b0, t2} + {4'h0, c_in};
      f     = sum[3:0];
      c_out = sum[4];
    end
  end

endmodule

// File: rtl/eclair_exec_unit.sv
// ECLair execution support: 16-bit 181 ALU, loadable up-counter (1 clk), 3-to-8 load decoder.
// ALU and decoder are combinational; ECLAIR_ALU_FLAGS_EN adds carry/zero/equal flags.
module eclair_exec_unit
  import eclair_exec_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  eclair_exec_unit_if.slave bus
);

  localparam int N_SLICE = ALU_WIDTH / 4;

  logic [CNT_WIDTH-1:0] cnt;
  logic [N_SLICE:0]     carry;
  logic [ALU_WIDTH-1:0] z;

  // Reset beats load beats increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.cnt_load) begin
      cnt <= bus.cnt_preset;
    end else if (bus.cnt_en) begin
      cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.cnt_out = cnt;

  assign bus.dmx_out = {{(DMX_WIDTH-1){1'b0}}, 1'b1} << bus.dmx_sel;

  assign carry[0] = bus.alu_c_in;

  for (genvar i = 0; i < N_SLICE; i++) begin : g_slice
    eclair_alu4_slice u_slice (
      .mode  (bus.alu_mode),
      .op    (bus.alu_op),
      .c_in  (carry[i]),
      .a     (bus.alu_x[4*i +: 4]),
      .b     (bus.alu_y[4*i +: 4]),
      .f     (z[4*i +: 4]),
      .c_out (carry[i+1])
    );
  end

  assign bus.alu_z = z;

`ifdef ECLAIR_ALU_FLAGS_EN
  assign bus.alu_c_out = carry[N_SLICE];
  assign bus.alu_zero  = (z == '0);
  assign bus.alu_eq    = (bus.alu_x == bus.alu_y);
`else
  logic unused_c_out;
  assign unused_c_out = carry[N_SLICE];
`endif

endmodule

// File: tb/tb_eclair_exec_unit.sv
// Directed bench for eclair_exec_unit: counter, decoder sweep, ALU vectors (flags if enabled).
module tb_eclair_exec_unit;
  import eclair_exec_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  eclair_exec_unit_if #(.CNT_WIDTH(16)) bus ();

  eclair_exec_unit #(.CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        mode;
    logic [3:0]  op;
    logic        c_in;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } alu_vec_t;

  alu_vec_t vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset          = 1'b1;
    bus.cnt_en     = 1'b0;
    bus.cnt_load   = 1'b0;
    bus.cnt_preset = 16'h0000;
    bus.alu_mode   = ALU_ARITH;
    bus.alu_op     = 4'h0;
    bus.alu_c_in   = 1'b0;
    bus.alu_x      = 16'h0000;
    bus.alu_y      = 16'h0000;
    bus.dmx_sel    = 3'd0;

    tick();
    tick();
    check("rst_cnt", 32'(bus.cnt_out), 32'h0);

    // Reset dominates load and enable on the same edge.
    bus.cnt_load   = 1'b1;
    bus.cnt_en     = 1'b1;
    bus.cnt_preset = 16'hABCD;
    tick();
    check("rst_over_load", 32'(bus.cnt_out), 32'h0);

    // Decoder must not care about reset.
    bus.dmx_sel = 3'd5;
    #1;
    check("dmx_in_reset", 32'(bus.dmx_out), 32'h20);

    reset        = 1'b0;
    bus.cnt_load = 1'b0;
    tick(); check("cnt_inc1", 32'(bus.cnt_out), 32'h1);
    tick(); check("cnt_inc2", 32'(bus.cnt_out), 32'h2);
    tick(); check("cnt_inc3", 32'(bus.cnt_out), 32'h3);

    bus.cnt_en = 1'b0;
    tick(); check("cnt_hold", 32'(bus.cnt_out), 32'h3);

    bus.cnt_load   = 1'b1;
    bus.cnt_en     = 1'b1;
    bus.cnt_preset = 16'hFFFE;
    tick(); check("cnt_load", 32'(bus.cnt_out), 32'hFFFE);
    bus.cnt_load = 1'b0;
    tick(); check("cnt_ffff", 32'(bus.cnt_out), 32'hFFFF);
    tick(); check("cnt_wrap", 32'(bus.cnt_out), 32'h0000);
    tick(); check("cnt_after_wrap", 32'(bus.cnt_out), 32'h0001);

    reset = 1'b1;
    tick(); check("cnt_mid_reset", 32'(bus.cnt_out), 32'h0);
    reset      = 1'b0;
    bus.cnt_en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d       = 8'h01 << i;
      bus.dmx_sel = 3'(i);
      #1;
      check($sformatf("dmx_%0d", i), 32'(bus.dmx_out), 32'(exp_d));
      check($sformatf("dmx_onehot_%0d", i), 32'($countones(bus.dmx_out)), 32'd1);
    end

    vecs.push_back('{ALU_ARITH, 4'h9, 1'b0, 16'h1234, 16'h1111, 16'h2345});
    vecs.push_back('{ALU_ARITH, 4'h6, 1'b1, 16'h0005, 16'h0007, 16'hFFFE});
    vecs.push_back('{ALU_ARITH, 4'h6, 1'b0, 16'h0005, 16'h0007, 16'hFFFD});
    vecs.push_back('{ALU_ARITH, 4'h9, 1'b0, 16'h00FF, 16'h0001, 16'h0100});
    vecs.push_back('{ALU_ARITH, 4'hF, 1'b0, 16'h0000, 16'h1234, 16'hFFFF});
    vecs.push_back('{ALU_ARITH, 4'hC, 1'b0, 16'h8001, 16'h0000, 16'h0002});
    vecs.push_back('{ALU_ARITH, 4'h3, 1'b1, 16'h5555, 16'hAAAA, 16'h0000});
    vecs.push_back('{ALU_ARITH, 4'h0, 1'b1, 16'h1234, 16'hFFFF, 16'h1235});
    vecs.push_back('{ALU_ARITH, 4'h4, 1'b0, 16'h0003, 16'h0006, 16'h0004});
    vecs.push_back('{ALU_ARITH, 4'h8, 1'b0, 16'h0003, 16'h0006, 16'h0005});
    vecs.push_back('{ALU_ARITH, 4'hA, 1'b0, 16'h00F0, 16'h0F00, 16'hF0FF});
    vecs.push_back('{ALU_LOGIC, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0});
    vecs.push_back('{ALU_LOGIC, 4'h6, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0});
    vecs.push_back('{ALU_LOGIC, 4'hB, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000});
    vecs.push_back('{ALU_LOGIC, 4'hE, 1'b0, 16'hF0F0, 16'hFF00, 16'hFFF0});
    vecs.push_back('{ALU_LOGIC, 4'h0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0F0F});
    vecs.push_back('{ALU_LOGIC, 4'h3, 1'b1, 16'hF0F0, 16'hFF00, 16'h0000});
    vecs.push_back('{ALU_LOGIC, 4'h9, 1'b0, 16'hF0F0, 16'hFF00, 16'hF00F});
    vecs.push_back('{ALU_LOGIC, 4'hD, 1'b0, 16'hF0F0, 16'hFF00, 16'hF0FF});

    foreach (vecs[i]) begin
      bus.alu_mode = vecs[i].mode;
      bus.alu_op   = vecs[i].op;
      bus.alu_c_in = vecs[i].c_in;
      bus.alu_x    = vecs[i].x;
      bus.alu_y    = vecs[i].y;
      #1;
      check($sformatf("alu_m%0d_op%h_v%0d", vecs[i].mode, vecs[i].op, i),
            32'(bus.alu_z), 32'(vecs[i].z));
    end

`ifdef ECLAIR_ALU_FLAGS_EN
    bus.alu_mode = ALU_ARITH;
    bus.alu_op   = 4'h9;
    bus.alu_c_in = 1'b0;
    bus.alu_x    = 16'hFFFF;
    bus.alu_y    = 16'h0001;
    #1;
    check("flg_z",    32'(bus.alu_z),     32'h0);
    check("flg_cout", 32'(bus.alu_c_out), 32'h1);
    check("flg_zero", 32'(bus.alu_zero),  32'h1);
    check("flg_eq",   32'(bus.alu_eq),    32'h0);
    bus.alu_mode = ALU_LOGIC;
    bus.alu_op   = 4'hC;
    bus.alu_x    = 16'h1234;
    bus.alu_y    = 16'h1234;
    #1;
    check("flg_logic_cout", 32'(bus.alu_c_out), 32'h0);
    check("flg_logic_zero", 32'(bus.alu_zero),  32'h0);
    check("flg_logic_eq",   32'(bus.alu_eq),    32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
